// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command sequencer: pin encodings,
// FSM states, mode register value, fixed timings and SADDR field layout.
package sdram_pkg;

  // {CS_N, RAS_N, CAS_N, WE_N}
  typedef enum logic [3:0] {
    CMD_LOAD_MODE = 4'b0000,
    CMD_REFRESH   = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVE    = 4'b0011,
    CMD_WRITE     = 4'b0100,
    CMD_READ      = 4'b0101,
    CMD_NOP       = 4'b0111,
    CMD_DESELECT  = 4'b1111
  } sdram_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RCD_WAIT,
    ST_BURST_WAIT,
    ST_PRE_WAIT,
    ST_REF_WAIT,
    ST_MRD_WAIT
  } seq_state_e;

  // Command chosen by the IDLE arbiter
  typedef enum logic [2:0] {
    PICK_NONE,
    PICK_LOAD_MODE,
    PICK_PRECHARGE,
    PICK_REFRESH,
    PICK_REF_REQ,
    PICK_ROW
  } idle_pick_e;

  localparam logic [12:0] MODE_REG = 13'h033;  // BL8, sequential, CL3
  localparam int unsigned T_MRD    = 2;
  localparam int unsigned T_WR     = 2;
  localparam int unsigned AP_BIT   = 10;       // SA bit: all banks / autoprecharge

  localparam int unsigned SADDR_W  = 25;
  localparam int unsigned BANK_LSB = 23;
  localparam int unsigned BANK_W   = 2;
  localparam int unsigned ROW_LSB  = 10;
  localparam int unsigned ROW_W    = 13;
  localparam int unsigned COL_LSB  = 0;
  localparam int unsigned COL_W    = 10;

  typedef logic [SADDR_W-1:0] saddr_t;

  function automatic logic [BANK_W-1:0] saddr_bank(input saddr_t a);
    return a[BANK_LSB +: BANK_W];
  endfunction

  function automatic logic [ROW_W-1:0] saddr_row(input saddr_t a);
    return a[ROW_LSB +: ROW_W];
  endfunction

  function automatic logic [COL_W-1:0] saddr_col(input saddr_t a);
    return a[COL_LSB +: COL_W];
  endfunction

endpackage

// File: rtl/sdram_cmd_sequencer_if.sv
// Request/acknowledge handshake plus SDRAM command pins of the sequencer.
interface sdram_cmd_sequencer_if;
  import sdram_pkg::*;

  saddr_t      SADDR;
  logic        READA;
  logic        WRITEA;
  logic        REFRESH;
  logic        PRECHARGE;
  logic        LOAD_MODE;
  logic        REF_REQ;
  logic        INIT_REQ;
  logic        REF_ACK;
  logic        INIT_ACK;
  logic        CM_ACK;
  logic        OE;
  logic        RD_VALID;
  logic [12:0] SA;
  logic [1:0]  BA;
  logic        CS_N;
  logic        RAS_N;
  logic        CAS_N;
  logic        WE_N;

  modport master (
    output SADDR, READA, WRITEA, REFRESH, PRECHARGE, LOAD_MODE, REF_REQ, INIT_REQ,
    input  REF_ACK, INIT_ACK, CM_ACK, OE, RD_VALID, SA, BA, CS_N, RAS_N, CAS_N, WE_N
  );

  modport slave (
    input  SADDR, READA, WRITEA, REFRESH, PRECHARGE, LOAD_MODE, REF_REQ, INIT_REQ,
    output REF_ACK, INIT_ACK, CM_ACK, OE, RD_VALID, SA, BA, CS_N, RAS_N, CAS_N, WE_N
  );
endinterface

// File: rtl/sdram_rd_valid_pipe.sv
// Read-data valid window: a pulse one cycle before the READ appears on the
// pins produces RD_VALID for BL cycles starting CL cycles after the READ.
module sdram_rd_valid_pipe #(
  parameter int unsigned CL = 3,
  parameter int unsigned BL = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic rd_issue,
  output logic rd_valid
);
  localparam int unsigned DEPTH = CL + BL;

  logic [DEPTH-1:0] sr_q;

  // Bit k is set k cycles after the READ is on the pins
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) sr_q <= '0;
    else       sr_q <= {sr_q[DEPTH-2:0], rd_issue};
  end

  assign rd_valid = |sr_q[DEPTH-1:CL];
endmodule

// File: rtl/sdram_cmd_sequencer.sv
// SDRAM command sequencer: arbitrates init, refresh and read/write requests
// and issues registered commands respecting ACTIVE/PRECHARGE/REFRESH timing.
module sdram_cmd_sequencer
  import sdram_pkg::*;
#(
  parameter int unsigned BL    = 8,
  parameter int unsigned CL    = 3,
  parameter int unsigned T_RCD = 3,
  parameter int unsigned T_RP  = 3,
  parameter int unsigned T_RC  = 8
) (
  input logic                 CLK,
  input logic                 RESET,
  sdram_cmd_sequencer_if.slave ctl
);
  localparam int unsigned CNT_W = 16;
  typedef logic [CNT_W-1:0] cnt_t;

  // Wait states return to IDLE one cycle early so the IDLE decision lands
  // exactly W cycles after the previous command; RCD_WAIT issues the column
  // command itself one cycle later, hence both use W-1 and differ in exit test.
  function automatic cnt_t wait_load(input int unsigned w);
    return (w == 0) ? '0 : cnt_t'(w - 1);
  endfunction

  seq_state_e  state_q, state_nxt;
  cnt_t        cnt_q, cnt_nxt;
  idle_pick_e  pick;
  logic        lm_pend_q, pre_pend_q, ref_pend_q;
  logic        lm_pend, pre_pend, ref_pend;
  saddr_t      addr_q;
  logic        wr_q;
  logic        col_go;

  sdram_cmd_e  cmd_nxt, cmd_q;
  logic [12:0] sa_nxt, sa_q;
  logic [1:0]  ba_nxt, ba_q;
  logic        ref_ack_nxt, init_ack_nxt, cm_ack_nxt;
  logic        ref_ack_q, init_ack_q, cm_ack_q;
  logic        rd_go, wr_go;
  cnt_t        oe_left_q;

  // A pulse arriving this cycle counts as pending so it can issue immediately
  assign lm_pend  = lm_pend_q  | ctl.LOAD_MODE;
  assign pre_pend = pre_pend_q | ctl.PRECHARGE;
  assign ref_pend = ref_pend_q | ctl.REFRESH;
  assign col_go   = (state_q == ST_RCD_WAIT) && (cnt_q == '0);

  // IDLE arbitration in fixed priority order
  always_comb begin
    pick = PICK_NONE;
    if (state_q == ST_IDLE && !ctl.INIT_REQ) begin
      if (lm_pend)                      pick = PICK_LOAD_MODE;
      else if (pre_pend)                pick = PICK_PRECHARGE;
      else if (ref_pend)                pick = PICK_REFRESH;
      else if (ctl.REF_REQ)             pick = PICK_REF_REQ;
      else if (ctl.READA || ctl.WRITEA) pick = PICK_ROW;
    end
  end

  // State and wait counter
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Next state: load the counter on every command, count down otherwise
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = (cnt_q != '0) ? cnt_q - cnt_t'(1) : cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        unique case (pick)
          PICK_LOAD_MODE: begin state_nxt = ST_MRD_WAIT; cnt_nxt = wait_load(T_MRD); end
          PICK_PRECHARGE: begin state_nxt = ST_PRE_WAIT; cnt_nxt = wait_load(T_RP);  end
          PICK_REFRESH,
          PICK_REF_REQ:   begin state_nxt = ST_REF_WAIT; cnt_nxt = wait_load(T_RC);  end
          PICK_ROW:       begin state_nxt = ST_RCD_WAIT; cnt_nxt = wait_load(T_RCD); end
          default: ;
        endcase
      end
      ST_RCD_WAIT: begin
        if (cnt_q == '0) begin
          state_nxt = ST_BURST_WAIT;
          cnt_nxt   = wr_q ? wait_load(BL + T_WR + T_RP) : wait_load(BL + T_RP);
        end
      end
      default: begin
        if (cnt_q < cnt_t'(2)) state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command, address and acknowledge values for the next pin cycle
  always_comb begin
    cmd_nxt      = CMD_NOP;
    sa_nxt       = '0;
    ba_nxt       = '0;
    ref_ack_nxt  = 1'b0;
    init_ack_nxt = 1'b0;
    cm_ack_nxt   = 1'b0;
    rd_go        = 1'b0;
    wr_go        = 1'b0;
    if (col_go) begin
      cmd_nxt    = wr_q ? CMD_WRITE : CMD_READ;
      sa_nxt     = {2'b00, 1'b1, saddr_col(addr_q)};
      ba_nxt     = saddr_bank(addr_q);
      cm_ack_nxt = 1'b1;
      rd_go      = !wr_q;
      wr_go      = wr_q;
    end else begin
      unique case (pick)
        PICK_LOAD_MODE: begin
          cmd_nxt      = CMD_LOAD_MODE;
          sa_nxt       = MODE_REG;
          init_ack_nxt = 1'b1;
        end
        PICK_PRECHARGE: begin
          cmd_nxt         = CMD_PRECHARGE;
          sa_nxt[AP_BIT]  = 1'b1;
        end
        PICK_REFRESH: cmd_nxt = CMD_REFRESH;
        PICK_REF_REQ: begin
          cmd_nxt     = CMD_REFRESH;
          ref_ack_nxt = 1'b1;
        end
        PICK_ROW: begin
          cmd_nxt = CMD_ACTIVE;
          sa_nxt  = saddr_row(ctl.SADDR);
          ba_nxt  = saddr_bank(ctl.SADDR);
        end
        default: ;
      endcase
    end
  end

  // Pending init pulses and the latched request address/direction
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lm_pend_q  <= 1'b0;
      pre_pend_q <= 1'b0;
      ref_pend_q <= 1'b0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
    end else begin
      lm_pend_q  <= lm_pend  && (pick != PICK_LOAD_MODE);
      pre_pend_q <= pre_pend && (pick != PICK_PRECHARGE);
      ref_pend_q <= ref_pend && (pick != PICK_REFRESH);
      if (pick == PICK_ROW) begin
        addr_q <= ctl.SADDR;
        wr_q   <= !ctl.READA;
      end
    end
  end

  // Registered pins, acknowledges and write-enable window
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cmd_q      <= CMD_DESELECT;
      sa_q       <= '0;
      ba_q       <= '0;
      ref_ack_q  <= 1'b0;
      init_ack_q <= 1'b0;
      cm_ack_q   <= 1'b0;
      oe_left_q  <= '0;
    end else begin
      cmd_q      <= cmd_nxt;
      sa_q       <= sa_nxt;
      ba_q       <= ba_nxt;
      ref_ack_q  <= ref_ack_nxt;
      init_ack_q <= init_ack_nxt;
      cm_ack_q   <= cm_ack_nxt;
      if (wr_go)                oe_left_q <= cnt_t'(BL);
      else if (oe_left_q != '0) oe_left_q <= oe_left_q - cnt_t'(1);
    end
  end

  sdram_rd_valid_pipe #(
    .CL(CL),
    .BL(BL)
  ) u_rd_valid (
    .CLK      (CLK),
    .RESET    (RESET),
    .rd_issue (rd_go),
    .rd_valid (ctl.RD_VALID)
  );

  assign {ctl.CS_N, ctl.RAS_N, ctl.CAS_N, ctl.WE_N} = cmd_q;
  assign ctl.SA       = sa_q;
  assign ctl.BA       = ba_q;
  assign ctl.REF_ACK  = ref_ack_q;
  assign ctl.INIT_ACK = init_ack_q;
  assign ctl.CM_ACK   = cm_ack_q;
  assign ctl.OE       = (oe_left_q != '0);
endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Directed bench for sdram_cmd_sequencer: per-cycle stimulus tables, a pin
// trace indexed by cycle offset from t0, and hand-computed expectations.
module tb_sdram_cmd_sequencer;
  import sdram_pkg::*;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  sdram_cmd_sequencer_if bus();

  sdram_cmd_sequencer #(
    .BL(8), .CL(3), .T_RCD(3), .T_RP(3), .T_RC(8)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .ctl   (bus)
  );

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] sa;
    logic        ref_ack;
    logic        init_ack;
    logic        cm_ack;
    logic        oe;
    logic        rd_valid;
  } snap_t;

  localparam int B_READA = 0, B_WRITEA = 1, B_REFRESH = 2, B_PRECHARGE = 3,
                 B_LOAD = 4, B_REFREQ = 5, B_INIT = 6;

  snap_t      tr   [64];
  logic [6:0] stim [64];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  function automatic snap_t snap();
    snap_t s;
    s.cmd      = {bus.CS_N, bus.RAS_N, bus.CAS_N, bus.WE_N};
    s.ba       = bus.BA;
    s.sa       = bus.SA;
    s.ref_ack  = bus.REF_ACK;
    s.init_ack = bus.INIT_ACK;
    s.cm_ack   = bus.CM_ACK;
    s.oe       = bus.OE;
    s.rd_valid = bus.RD_VALID;
    return s;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply(input logic [6:0] v);
    bus.READA     = v[B_READA];
    bus.WRITEA    = v[B_WRITEA];
    bus.REFRESH   = v[B_REFRESH];
    bus.PRECHARGE = v[B_PRECHARGE];
    bus.LOAD_MODE = v[B_LOAD];
    bus.REF_REQ   = v[B_REFREQ];
    bus.INIT_REQ  = v[B_INIT];
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 64; i++) stim[i] = '0;
  endtask

  task automatic hold(input int b, input int from, input int to);
    for (int i = from; i <= to; i++) stim[i][b] = 1'b1;
  endtask

  // stim[i] is driven in cycle t0+i; tr[i] holds the pins seen in cycle t0+i
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      apply(stim[i]);
      tick();
      tr[i+1] = snap();
    end
    apply('0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int first_cmd(input int from, input int to);
    for (int i = from; i <= to; i++)
      if (tr[i].cmd != CMD_NOP) return i;
    return 99;
  endfunction

  function automatic int count_cmds(input int from, input int to);
    int n = 0;
    for (int i = from; i <= to; i++) if (tr[i].cmd != CMD_NOP) n++;
    return n;
  endfunction

  function automatic int count_acks(input int from, input int to);
    int n = 0;
    for (int i = from; i <= to; i++) n += int'(tr[i].ref_ack) + int'(tr[i].init_ack) + int'(tr[i].cm_ack);
    return n;
  endfunction

  // sel: 0 OE, 1 RD_VALID, 2 CM_ACK, 3 REF_ACK; bit i = value in cycle t0+i
  function automatic logic [31:0] mask_of(input int sel, input int from, input int to);
    logic [31:0] m = '0;
    for (int i = from; i <= to; i++) begin
      case (sel)
        0:       m[i] = tr[i].oe;
        1:       m[i] = tr[i].rd_valid;
        2:       m[i] = tr[i].cm_ack;
        default: m[i] = tr[i].ref_ack;
      endcase
    end
    return m;
  endfunction

  initial begin
    bus.SADDR = '0;
    apply('0);

    // reset state
    #2 RESET = 1'b1;
    #1;
    check("rst_pins", {bus.CS_N, bus.RAS_N, bus.CAS_N, bus.WE_N}, 4'hF);
    check("rst_addr", {bus.BA, bus.SA}, 15'h0);
    check("rst_flags", {bus.REF_ACK, bus.INIT_ACK, bus.CM_ACK, bus.OE, bus.RD_VALID}, 5'b0);
    gap(3);
    @(negedge CLK);
    RESET = 1'b0;
    tick();
    check("idle_nop", {bus.CS_N, bus.RAS_N, bus.CAS_N, bus.WE_N}, 4'b0111);
    gap(2);

    // INIT_REQ masks everything for 50 cycles
    clear_stim();
    bus.SADDR = {2'd1, 13'h0055, 10'h0AA};
    hold(B_INIT, 0, 49); hold(B_REFREQ, 0, 49); hold(B_READA, 0, 49);
    run(50);
    check("init_cmds", count_cmds(1, 50), 0);
    check("init_acks", count_acks(1, 50), 0);
    check("init_nop", tr[50].cmd, 4'b0111);
    gap(3);

    // init pulses: PRECHARGE, REFRESH, then LOAD_MODE while REFRESH runs
    clear_stim();
    hold(B_PRECHARGE, 0, 0); hold(B_REFRESH, 1, 1); hold(B_LOAD, 4, 4);
    run(20);
    check("seq_pre_at", first_cmd(1, 20), 1);
    check("seq_pre_cmd", tr[1].cmd, 4'b0010);
    check("seq_pre_sa", tr[1].sa, 13'h0400);
    check("seq_ref_at", first_cmd(2, 20), 4);
    check("seq_ref_cmd", tr[4].cmd, 4'b0001);
    check("seq_ref_noack", tr[4].ref_ack, 1'b0);
    check("seq_lm_at", first_cmd(5, 20), 12);
    check("seq_lm", {tr[12].cmd, tr[12].ba, tr[12].sa, tr[12].init_ack}, {4'b0000, 2'd0, 13'h033, 1'b1});
    check("seq_tail", count_cmds(13, 20), 0);
    gap(3);

    // LOAD_MODE outranks REFRESH once both are pending; repeat REFRESH merges
    clear_stim();
    hold(B_PRECHARGE, 0, 0); hold(B_REFRESH, 1, 1); hold(B_LOAD, 2, 2); hold(B_REFRESH, 3, 3);
    run(25);
    check("prio_lm_at", first_cmd(2, 25), 4);
    check("prio_lm_cmd", tr[4].cmd, 4'b0000);
    check("prio_ref_at", first_cmd(5, 25), 6);
    check("prio_ref_cmd", tr[6].cmd, 4'b0001);
    check("prio_merged", count_cmds(7, 25), 0);
    gap(3);

    // READA bank 2 row 0x1ABC col 0x155; REF_REQ raised during the burst
    clear_stim();
    bus.SADDR = {2'd2, 13'h1ABC, 10'h155};
    hold(B_READA, 0, 3); hold(B_REFREQ, 5, 14);
    run(24);
    check("rd_act", {tr[1].cmd, tr[1].ba, tr[1].sa}, {4'b0011, 2'd2, 13'h1ABC});
    check("rd_gap", first_cmd(2, 24), 4);
    check("rd_cmd", {tr[4].cmd, tr[4].ba, tr[4].sa}, {4'b0101, 2'd2, 13'h0555});
    check("rd_cm_ack", mask_of(2, 1, 24), 32'h0000_0010);
    check("rd_valid", mask_of(1, 1, 24), 32'h0000_7F80);
    check("rd_oe", mask_of(0, 1, 24), 32'h0);
    check("rd_next_at", first_cmd(5, 24), 15);
    check("rd_next_ref", {tr[15].cmd, tr[15].ref_ack}, {4'b0001, 1'b1});
    gap(3);

    // WRITEA col 0; REF_REQ raised during the burst
    clear_stim();
    bus.SADDR = {2'd1, 13'h0123, 10'h000};
    hold(B_WRITEA, 0, 3); hold(B_REFREQ, 5, 16);
    run(28);
    check("wr_act", {tr[1].cmd, tr[1].ba, tr[1].sa}, {4'b0011, 2'd1, 13'h0123});
    check("wr_cmd", {tr[4].cmd, tr[4].ba, tr[4].sa, tr[4].cm_ack}, {4'b0100, 2'd1, 13'h0400, 1'b1});
    check("wr_oe", mask_of(0, 1, 28), 32'h0000_0FF0);
    check("wr_rdv", mask_of(1, 1, 28), 32'h0);
    check("wr_next_at", first_cmd(5, 28), 17);
    check("wr_next_ref", tr[17].cmd, 4'b0001);
    gap(3);

    // REF_REQ beats a simultaneous WRITEA
    clear_stim();
    bus.SADDR = {2'd3, 13'h0F0F, 10'h3FF};
    hold(B_REFREQ, 0, 0); hold(B_WRITEA, 0, 11);
    run(30);
    check("rw_ref", {tr[1].cmd, tr[1].ref_ack}, {4'b0001, 1'b1});
    check("rw_act_at", first_cmd(2, 30), 9);
    check("rw_act", {tr[9].cmd, tr[9].ba, tr[9].sa}, {4'b0011, 2'd3, 13'h0F0F});
    check("rw_wr", {tr[12].cmd, tr[12].sa}, {4'b0100, 13'h07FF});
    check("rw_ref_ack", mask_of(3, 1, 30), 32'h0000_0002);
    gap(3);

    // RESET two cycles after WRITE aborts the burst immediately
    clear_stim();
    bus.SADDR = {2'd0, 13'h0777, 10'h011};
    hold(B_WRITEA, 0, 3);
    run(6);
    check("rs_wr", tr[4].cmd, 4'b0100);
    check("rs_oe_before", tr[6].oe, 1'b1);
    #2 RESET = 1'b1;
    #1;
    check("rs_pins", {bus.CS_N, bus.RAS_N, bus.CAS_N, bus.WE_N}, 4'hF);
    check("rs_oe", bus.OE, 1'b0);
    check("rs_addr", {bus.BA, bus.SA}, 15'h0);
    bus.WRITEA = 1'b1;
    begin
      int quiet = 0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if ({bus.CS_N, bus.RAS_N, bus.CAS_N, bus.WE_N} == 4'hF && !bus.OE) quiet++;
      end
      check("rs_hold", quiet, 4);
    end
    @(negedge CLK);
    RESET = 1'b0;
    tick();
    check("rs_first", {bus.CS_N, bus.RAS_N, bus.CAS_N, bus.WE_N, bus.BA, bus.SA},
          {4'b0011, 2'd0, 13'h0777});
    bus.WRITEA = 1'b0;
    gap(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
